// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer.
// Contents:
//   XLEN              instruction / address width
//   RESET_PC          PC value the PC register loads on reset (trace/checking only)
//   TRAP_VEC          next PC on a misaligned redirect (PC_ALIGN_CHECK_EN builds)
//   PC_STEP_DEF       default sequential increment in bytes
//   state_t, ST_*     FSM state encoding: BOOT, FETCH, ISSUE, DRAIN
package fetch_sequencer_pkg;

  localparam int          XLEN        = 32;
  localparam logic [31:0] RESET_PC    = 32'h0100_0000;
  localparam logic [31:0] TRAP_VEC    = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_BOOT  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_ISSUE = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM sitting between the PC register, the
// instruction memory port and decode.
//
// Optional feature: define PC_ALIGN_CHECK_EN to trap misaligned redirects
// (pc_next = TRAP_VEC and a one-cycle misalign_err pulse). Without it,
// misalign_err is tied low and redirect_pc is used verbatim.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   pc_cur            current PC from the PC register
//   pc_en, pc_next    PC register enable / data (register gives en priority over rst)
//   imem_req/addr     fetch request and address (addr follows pc_cur)
//   imem_ack/rdata    fetch completion and word, valid in the ack cycle
//   instr_valid/ready downstream handshake; instr/instr_pc held until accepted
//   stall             blocks accept and PC advance (not redirects)
//   redirect_valid/pc branch/jump taken and its target
//   misalign_err      misaligned-redirect pulse (PC_ALIGN_CHECK_EN only)
//   o_dbg_state       current FSM state, for trace and checkers
//
// Handshakes: imem_req stays high until the cycle imem_ack is seen; downstream
// transfer happens in a cycle where instr_valid && instr_ready && !stall and no
// redirect is present (a redirect in that cycle cancels the transfer).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_STEP = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_cur,
  output logic            pc_en,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err,
  output state_t          o_dbg_state
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            w_redir;
  logic            w_accept;
  logic            w_capture;
  logic [XLEN-1:0] w_redir_target;
  logic            w_misalign;

  // Combinational outputs are gated by rst so a reset mid-fetch drops the
  // request immediately rather than on the following edge.
  always_comb begin
    w_redir     = !rst && redirect_valid && (r_state != ST_BOOT);
    w_accept    = !rst && (r_state == ST_ISSUE) && instr_ready && !stall && !w_redir;
    w_capture   = (r_state == ST_FETCH) && imem_ack && !w_redir;
    imem_req    = !rst && ((r_state == ST_FETCH) || (r_state == ST_DRAIN));
    imem_addr   = pc_cur;
    instr_valid = !rst && (r_state == ST_ISSUE);
    o_dbg_state = r_state;
  end

`ifdef PC_ALIGN_CHECK_EN
  always_comb begin
    w_misalign     = w_redir && (redirect_pc[1:0] != 2'b00);
    w_redir_target = w_misalign ? TRAP_VEC : redirect_pc;
  end
`else
  always_comb begin
    w_misalign     = 1'b0;
    w_redir_target = redirect_pc;
  end
`endif

  // Next-PC mux: redirect beats sequential advance; +STEP wraps mod 2^XLEN.
  always_comb begin
    pc_en        = w_redir || w_accept;
    pc_next      = w_redir ? w_redir_target : (pc_cur + STEP);
    misalign_err = w_misalign;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:  w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        // A redirect with no ack leaves a request outstanding that must be
        // drained; with an ack the stale word is simply dropped.
        if (w_redir)       w_state_nxt = imem_ack ? ST_FETCH : ST_DRAIN;
        else if (imem_ack) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_redir || w_accept) w_state_nxt = ST_FETCH;
      end
      ST_DRAIN: begin
        if (w_redir || imem_ack) w_state_nxt = ST_FETCH;
      end
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= pc_cur;
      end
    end
  end

  assign instr    = r_instr;
  assign instr_pc = r_instr_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC register model, a memory model
// with programmable ack latency, and a scoreboard of accepted instructions.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pc_cur;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;
  state_t      dbg_state;

  int vectors;
  int miscompares;
  int mem_wait;
  int wait_cnt;
  logic [63:0] exp_q[$];

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_en(pc_en), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .misalign_err(misalign_err), .o_dbg_state(dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // PC register model: enable has priority over reset.
  always @(posedge clk) begin
    if (pc_en)    pc_cur <= pc_next;
    else if (rst) pc_cur <= RESET_PC;
  end

  // Memory model: acks after mem_wait cycles of a held request.
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  always_comb begin
    imem_ack   = imem_req && (wait_cnt >= mem_wait);
    imem_rdata = word_of(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, word_of(pc)});
  endtask

  // Scoreboard: pop and compare on every downstream transfer.
  task automatic sb();
    logic [63:0] e;
    if (!rst && instr_valid && instr_ready && !stall && !redirect_valid) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL sb_unexpected: observed accept of pc %08h expected none", instr_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", instr_pc, e[63:32]);
        chk("sb_instr", instr, e[31:0]);
      end
    end
  endtask

  // Driver: inputs change at posedge+1, checks run at posedge+3.
  task automatic tick();
    #3;
    sb();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp6_pc;
  logic [31:0] exp6_mis;

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; instr_ready = 1'b1; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; mem_wait = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state
    #2;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_pc_en", {31'b0, pc_en}, 32'd0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_BOOT});
    tick();

    // BOOT: redirect ignored
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    #2;
    chk("boot_state", {30'b0, dbg_state}, {30'b0, ST_BOOT});
    chk("boot_redir_ignored", {31'b0, pc_en}, 32'd0);
    chk("boot_req", {31'b0, imem_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;

    // 1: zero-wait streaming
    for (int i = 0; i < 3; i++) begin
      push_exp(RESET_PC + 32'(4 * i));
      #2;
      chk("t1_req", {31'b0, imem_req}, 32'd1);
      chk("t1_addr", imem_addr, RESET_PC + 32'(4 * i));
      chk("t1_pc_en_fetch", {31'b0, pc_en}, 32'd0);
      tick();
      #2;
      chk("t1_valid", {31'b0, instr_valid}, 32'd1);
      chk("t1_pc_en_issue", {31'b0, pc_en}, 32'd1);
      chk("t1_pc_next", pc_next, RESET_PC + 32'(4 * i + 4));
      tick();
    end

    // 2: ack delayed by 3 cycles
    mem_wait = 3;
    for (int j = 0; j < 4; j++) begin
      #2;
      chk("t2_req_held", {31'b0, imem_req}, 32'd1);
      chk("t2_addr_stable", imem_addr, 32'h0100_000C);
      chk("t2_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});
      tick();
    end

    // 3: stall in ISSUE for 5 cycles
    stall = 1'b1;
    push_exp(32'h0100_000C);
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("t3_valid", {31'b0, instr_valid}, 32'd1);
      chk("t3_instr", instr, word_of(32'h0100_000C));
      chk("t3_pc_en", {31'b0, pc_en}, 32'd0);
      tick();
    end
    stall = 1'b0;
    #2;
    chk("t3_adv_en", {31'b0, pc_en}, 32'd1);
    chk("t3_adv_next", pc_next, 32'h0100_0010);
    tick();

    // 4: redirect in FETCH with the ack one cycle later -> DRAIN
    mem_wait = 1;
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0100;
    #2;
    chk("t4_pc_en", {31'b0, pc_en}, 32'd1);
    chk("t4_pc_next", pc_next, 32'h0100_0100);
    chk("t4_misalign", {31'b0, misalign_err}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #2;
    chk("t4_drain", {30'b0, dbg_state}, {30'b0, ST_DRAIN});
    chk("t4_drain_req", {31'b0, imem_req}, 32'd1);
    chk("t4_drain_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    #2;
    chk("t4_refetch_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});
    chk("t4_refetch_addr", imem_addr, 32'h0100_0100);
    tick();
    tick();

    // 5: redirect and ready in the same ISSUE cycle
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0200; instr_ready = 1'b1;
    #2;
    chk("t5_instr_pc", instr_pc, 32'h0100_0100);
    chk("t5_pc_en", {31'b0, pc_en}, 32'd1);
    chk("t5_pc_next", pc_next, 32'h0100_0200);
    tick();
    redirect_valid = 1'b0; mem_wait = 0;
    push_exp(32'h0100_0200);
    #2;
    chk("t5_valid_drop", {31'b0, instr_valid}, 32'd0);
    chk("t5_addr", imem_addr, 32'h0100_0200);
    tick();
    #2;
    chk("t5_seq_next", pc_next, 32'h0100_0204);
    tick();

    // 6: misaligned redirect in FETCH with a same-cycle ack
`ifdef PC_ALIGN_CHECK_EN
    exp6_pc = TRAP_VEC; exp6_mis = 32'd1;
`else
    exp6_pc = 32'h0100_0102; exp6_mis = 32'd0;
`endif
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0102;
    #2;
    chk("t6_pc_en", {31'b0, pc_en}, 32'd1);
    chk("t6_pc_next", pc_next, exp6_pc);
    chk("t6_misalign", {31'b0, misalign_err}, exp6_mis);
    tick();
    redirect_valid = 1'b0;
    #2;
    chk("t6_misalign_pulse", {31'b0, misalign_err}, 32'd0);
    chk("t6_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});
    chk("t6_addr", imem_addr, exp6_pc);
    tick();

    // Wrap: +4 from the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #2;
    chk("wrap_redir", pc_next, 32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    push_exp(32'hFFFF_FFFC);
    #2;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    #2;
    chk("wrap_pc_en", {31'b0, pc_en}, 32'd1);
    chk("wrap_pc_next", pc_next, 32'h0000_0000);
    tick();

    // Redirect in DRAIN with a same-cycle ack
    mem_wait = 1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_pc = 32'h0000_0300;
    #2;
    chk("drain_redir_state", {30'b0, dbg_state}, {30'b0, ST_DRAIN});
    chk("drain_redir_next", pc_next, 32'h0000_0300);
    tick();
    redirect_valid = 1'b0;
    #2;
    chk("drain_done_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});
    chk("drain_done_addr", imem_addr, 32'h0000_0300);
    tick();

    // Reset mid-fetch abandons the request
    mem_wait = 3;
    rst = 1'b1;
    #2;
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    chk("midrst_pc_en", {31'b0, pc_en}, 32'd0);
    tick();
    #2;
    chk("midrst_state", {30'b0, dbg_state}, {30'b0, ST_BOOT});
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_pc", pc_cur, RESET_PC);
    rst = 1'b0;
    tick();

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL sb_leftover: observed %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
